cpu_seq: RTL and testbench
==========================

# cpu_seq

Instruction sequencer for the 8-bit accumulator CPU, sitting directly upstream of the ALU. It owns the program counter, the instruction register and the 2-bit instruction-cycle state. It drives `instruction` and `state` to the ALU, and generates memory address and read/write strobes. It also executes control-flow opcodes (JMP, JZ, HALT) that the ALU ignores.

## Interface
- No parameters.
- reset  input  1  asynchronous, active-high reset
- tclk  input  1  clock, all state updates on rising edge
- mem_ready  input  1  memory access completes this cycle (used only with SEQ_WAIT_EN)
- d_bus  input  8  shared data bus; sequencer only samples it (IR load)
- z  input  1  zero flag from ALU
- c  input  1  carry flag from ALU (reserved, unused by decode)
- instruction  output  8  instruction register
- state  output  2  cycle state: FETCH=00, DECODE=01, EXEC_A=10, EXEC_B=11
- pc  output  5  program counter
- mem_addr  output  5  memory address
- mem_rd  output  1  memory drives d_bus this cycle
- mem_wr  output  1  memory samples d_bus at end of this cycle
- halted  output  1  HALT executed; sequencer frozen

## Operation
- Opcode = instruction[7:5], operand = instruction[4:0].
- Opcodes: 000 ADD, 001 SUB, 010 NAND, 011 SHIFT, 100 LD, 101 ST, 110 JMP, 111 JZ. Opcode 111 with operand 5'h1f is HALT.
- State cycle: FETCH -> DECODE -> EXEC_A -> EXEC_B -> FETCH. Every instruction takes all four states; there is no early exit.
- FETCH: mem_addr=pc, mem_rd=1. On an advancing edge, instruction <= d_bus.
- DECODE: pc <= pc+1, modulo 32, so 31 wraps to 0. No memory access.
- EXEC_A: mem_rd=1 only for LD.
- EXEC_B:
  - mem_rd=1 for ADD, SUB and NAND.
  - mem_wr=1 for ST.
  - JMP: pc <= operand.
  - JZ (operand≠1f): pc <= operand if z=1, else pc unchanged.
  - HALT: halted <= 1.
- mem_addr = pc in FETCH, operand in all other states. It is combinational from state/pc/instruction.
- mem_rd and mem_wr are combinational decodes of state and opcode. They are never both 1.
- Halted behaviour:
  - state returns to FETCH and stays there.
  - pc and instruction are held.
  - mem_rd and mem_wr are forced to 0.
  - Only reset clears halted.
- z is sampled at the EXEC_B edge. The flag from the preceding instruction's EXEC_B is therefore the one tested.

## Timing
- Reset values: state=FETCH, pc=0, instruction=8'h00, halted=0. mem_rd=1 and mem_addr=0 follow combinationally from the FETCH state.
- Reset is asynchronous at any point, including mid-stall or while halted. It returns the sequencer to the reset values immediately.
- Without stalls, one instruction takes 4 cycles.
- A branch target is fetched in the FETCH immediately after the branch's EXEC_B, with no bubble.
- The DECODE increment and the EXEC_B branch load are in different states, so they never collide.
- A stall is a cycle in which a state with mem_rd or mem_wr asserted does not advance (mem_ready=0). During a stall, strobes, mem_addr, pc and instruction are held stable.
- DECODE never stalls.
- EXEC_A and EXEC_B of non-memory opcodes never stall.

## Configuration
- `SEQ_WAIT_EN` defined:
  - A state with mem_rd or mem_wr asserted advances only on an edge with mem_ready=1.
  - The IR loads only on the FETCH edge where mem_ready=1.
- `SEQ_WAIT_EN` undefined:
  - mem_ready is ignored, treated as constant 1.
  - Every state lasts exactly one cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding constants FETCH, DECODE, EXEC_A, EXEC_B;
  - opcode constants OP_ADD through OP_JZ;
  - HALT_OPERAND = 5'h1f.
- The ALU and this block both import `cpu_pkg`.
- One sub-module: `seq_pc`, a 5-bit program counter with synchronous increment and load, where load has priority, plus async reset.
- All state machine and decode logic stays in `cpu_seq`.

## Test plan
- Reset, then memory[0]=8'h83 (LD 3) with no stalls.
  - Required: state sequence 00,01,10,11; mem_rd in FETCH and EXEC_A; mem_addr 0 then 3; pc=1 after DECODE.
- ST 5 (8'hA5) at pc=2.
  - Required: mem_wr=1 only in EXEC_B with mem_addr=5; mem_rd=0 in that cycle; pc=3.
- JZ 10 (8'hEA), once with z=0 and once with z=1.
  - Required: next FETCH has mem_addr=pc+1 for z=0, and mem_addr=10 for z=1.
- Straight-line code at pc=31.
  - Required: pc wraps to 0 after DECODE. JMP 7 (8'hC7) then fetches from address 7.
- With SEQ_WAIT_EN, mem_ready=0 for 3 cycles in FETCH.
  - Required: state stays 00, instruction unchanged; IR loads on the first mem_ready=1 edge.
  - Assert reset mid-stall: state=00, pc=0 immediately.
- HALT (8'hFF).
  - Required: halted=1 after EXEC_B; state stays 00, mem_rd=0 and pc frozen for 10 cycles; reset clears halted.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared cycle-state encoding and opcode constants for the accumulator CPU
package cpu_pkg;
  typedef enum logic [1:0] {FETCH = 2'b00, DECODE = 2'b01, EXEC_A = 2'b10, EXEC_B = 2'b11} state_t;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_LD    = 3'b100;
  localparam logic [2:0] OP_ST    = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_JZ    = 3'b111;
  localparam logic [4:0] HALT_OPERAND = 5'h1f;
endpackage

// File: rtl/seq_pc.sv
// seq_pc: 5-bit program counter, load has priority over increment
module seq_pc (
  input  logic       tclk,
  input  logic       reset,
  input  logic       inc,
  input  logic       ld,
  input  logic [4:0] d,
  output logic [4:0] pc
);
  always_ff @(posedge tclk or posedge reset)
    if (reset) pc <= '0;
    else if (ld) pc <= d;
    else if (inc) pc <= pc + 5'd1;
endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: instruction sequencer (PC, IR, cycle state, memory strobes, JMP/JZ/HALT)
// Define SEQ_WAIT_EN to make memory-access states wait for mem_ready.
module cpu_seq
  import cpu_pkg::*;
(
  input  logic       reset,
  input  logic       tclk,
  input  logic       mem_ready,
  input  logic [7:0] d_bus,
  input  logic       z,
  input  logic       c,
  output logic [7:0] instruction,
  output logic [1:0] state,
  output logic [4:0] pc,
  output logic [4:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted
);
  state_t st, st_nxt;
  logic [2:0] op;
  logic [4:0] opnd;
  logic ready, adv, is_halt, pc_ld, pc_inc;
  assign op = instruction[7:5];
  assign opnd = instruction[4:0];
  assign state = st;
`ifdef SEQ_WAIT_EN
  assign ready = mem_ready;
  logic unused_c;
  assign unused_c = c;
`else
  assign ready = 1'b1;
  logic unused_in;
  assign unused_in = c ^ mem_ready;
`endif
  always_comb begin
    mem_rd = !halted && (st == FETCH || (st == EXEC_A && op == OP_LD) ||
             (st == EXEC_B && (op == OP_ADD || op == OP_SUB || op == OP_NAND)));
    mem_wr = !halted && st == EXEC_B && op == OP_ST;
    mem_addr = st == FETCH ? pc : opnd;
    adv = !halted && (ready || !(mem_rd || mem_wr));
    is_halt = op == OP_JZ && opnd == HALT_OPERAND;
    pc_ld = adv && st == EXEC_B && (op == OP_JMP || (op == OP_JZ && !is_halt && z));
    pc_inc = adv && st == DECODE;
    st_nxt = halted ? FETCH : adv ? state_t'(st + 2'd1) : st;
  end
  always_ff @(posedge tclk or posedge reset)
    if (reset) begin
      st <= FETCH;
      instruction <= 8'h00;
      halted <= 1'b0;
    end else begin
      st <= st_nxt;
      if (adv && st == FETCH) instruction <= d_bus;
      if (adv && st == EXEC_B && is_halt) halted <= 1'b1;
    end
  seq_pc u_pc (
    .tclk  (tclk),
    .reset (reset),
    .inc   (pc_inc),
    .ld    (pc_ld),
    .d     (opnd),
    .pc    (pc)
  );
endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: table-driven program run with a scoreboard queue for cpu_seq
module tb_cpu_seq;
  import cpu_pkg::*;
  logic tclk = 1'b0, reset = 1'b1, mem_ready = 1'b1, z = 1'b0, c = 1'b0;
  logic [7:0] d_bus, instruction;
  logic [1:0] state;
  logic [4:0] pc, mem_addr;
  logic mem_rd, mem_wr, halted;
  logic [7:0] mem [32];
  typedef struct packed {
    logic [1:0] st;
    logic [4:0] pc;
    logic [7:0] ir;
    logic [4:0] addr;
    logic rd, wr, h;
  } obs_t;
  typedef struct {
    logic [4:0] at;
    logic [7:0] op;
    logic       z;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [4:0] pc_dec;
  } row_t;
  obs_t q[$];
  int total = 0, bad = 0;
  always #5 tclk = ~tclk;
  assign d_bus = mem_rd ? mem[mem_addr] : 8'h00;
  cpu_seq dut (
    .reset       (reset),
    .tclk        (tclk),
    .mem_ready   (mem_ready),
    .d_bus       (d_bus),
    .z           (z),
    .c           (c),
    .instruction (instruction),
    .state       (state),
    .pc          (pc),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .halted      (halted)
  );
  task automatic chk(input string name, input obs_t e);
    obs_t a;
    a = {state, pc, instruction, mem_addr, mem_rd, mem_wr, halted};
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s #%0d: got st=%0d pc=%0d ir=%h addr=%0d rd=%b wr=%b halted=%b, want st=%0d pc=%0d ir=%h addr=%0d rd=%b wr=%b halted=%b",
               name, total, a.st, a.pc, a.ir, a.addr, a.rd, a.wr, a.h, e.st, e.pc, e.ir, e.addr, e.rd, e.wr, e.h);
    end
  endtask
  task automatic push(input logic [1:0] st, input logic [4:0] p, input logic [7:0] ir,
                      input logic [4:0] addr, input logic rd, input logic wr, input logic h);
    obs_t e;
    e.st = st; e.pc = p; e.ir = ir; e.addr = addr; e.rd = rd; e.wr = wr; e.h = h;
    q.push_back(e);
  endtask
  initial begin
    row_t rows[8];
    logic [7:0] prev;
    obs_t rst_e;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h83; mem[1] = 8'h00; mem[2] = 8'hA5; mem[3] = 8'hEA;
    mem[4] = 8'hEA; mem[10] = 8'hDF; mem[31] = 8'hC7; mem[7] = 8'hFF;
    rows[0] = '{5'd0,  8'h83, 1'b0, 4'b0101, 4'b0000, 5'd1};
    rows[1] = '{5'd1,  8'h00, 1'b0, 4'b1001, 4'b0000, 5'd2};
    rows[2] = '{5'd2,  8'hA5, 1'b0, 4'b0001, 4'b1000, 5'd3};
    rows[3] = '{5'd3,  8'hEA, 1'b0, 4'b0001, 4'b0000, 5'd4};
    rows[4] = '{5'd4,  8'hEA, 1'b1, 4'b0001, 4'b0000, 5'd5};
    rows[5] = '{5'd10, 8'hDF, 1'b0, 4'b0001, 4'b0000, 5'd11};
    rows[6] = '{5'd31, 8'hC7, 1'b0, 4'b0001, 4'b0000, 5'd0};
    rows[7] = '{5'd7,  8'hFF, 1'b1, 4'b0001, 4'b0000, 5'd8};
    rst_e = {2'd0, 5'd0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
    fork
      forever begin
        @(negedge tclk);
        if (q.size() > 0) chk("seq", q.pop_front());
      end
    join_none
    repeat (2) @(posedge tclk);
    #1 reset = 1'b0;
    chk("reset", rst_e);
    prev = 8'h00;
    foreach (rows[r]) begin
      for (int s = 0; s < 4; s++) begin
        z = rows[r].z;
`ifdef SEQ_WAIT_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'($urandom_range(0, 1));
`endif
        push(2'(s), s < 2 ? rows[r].at : rows[r].pc_dec, s == 0 ? prev : rows[r].op,
             s == 0 ? rows[r].at : rows[r].op[4:0], rows[r].rd[s], rows[r].wr[s], 1'b0);
        @(posedge tclk);
        #1;
      end
      prev = rows[r].op;
    end
    for (int i = 0; i < 10; i++) begin
      z = 1'($urandom_range(0, 1));
`ifndef SEQ_WAIT_EN
      mem_ready = 1'($urandom_range(0, 1));
`endif
      push(2'd0, 5'd8, 8'hFF, 5'd8, 1'b0, 1'b0, 1'b1);
      @(posedge tclk);
      #1;
    end
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1 chk("reset_halted", rst_e);
    #1 reset = 1'b0;
    @(posedge tclk);
    #1 chk("after_halt_reset", {2'd1, 5'd0, 8'h83, 5'd3, 1'b0, 1'b0, 1'b0});
`ifdef SEQ_WAIT_EN
    reset = 1'b1;
    #2 reset = 1'b0;
    mem_ready = 1'b0;
    repeat (3) begin
      push(2'd0, 5'd0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);
      @(posedge tclk);
      #1;
    end
    mem_ready = 1'b1;
    push(2'd0, 5'd0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);
    @(posedge tclk);
    #1 push(2'd1, 5'd0, 8'h83, 5'd3, 1'b0, 1'b0, 1'b0);
    @(posedge tclk);
    #1 mem_ready = 1'b0;
    repeat (2) begin
      push(2'd2, 5'd1, 8'h83, 5'd3, 1'b1, 1'b0, 1'b0);
      @(posedge tclk);
      #1;
    end
    #2 reset = 1'b1;
    #1 chk("reset_mid_stall", rst_e);
    #1 reset = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
